// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter: frame-granular AXI-stream arbiter with registered output.
// Define AXIS_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module axis_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  localparam int GW        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        async_rst,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  output logic                        grant_valid,
  output logic [GW-1:0]               grant_encoded
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                r_state, w_state_nxt;
  logic [GW-1:0]         r_grant, w_win;
  logic                  r_tvalid, r_tlast, r_tuser;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  w_any, w_ready, w_accept, w_last;

  assign w_any    = |input_axis_tvalid;
  // Skid-free ready: accept only when the output register is empty or draining this cycle
  assign w_ready  = (r_state == BUSY) & (output_axis_tready | ~r_tvalid);
  assign w_accept = w_ready & input_axis_tvalid[r_grant];
  assign w_last   = w_accept & input_axis_tlast[r_grant];

  assign input_axis_tready  = {{(PORTS-1){1'b0}}, w_ready} << r_grant;
  assign output_axis_tdata  = r_tdata;
  assign output_axis_tvalid = r_tvalid;
  assign output_axis_tlast  = r_tlast;
  assign output_axis_tuser  = r_tuser;
  assign grant_valid        = (r_state == BUSY);
  assign grant_encoded      = r_grant;

`ifdef AXIS_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] r_last_grant;
  // Walk the search order backwards so the first requester after last_grant is assigned last
  always_comb begin
    w_win = '0;
    for (int k = PORTS-1; k >= 0; k--)
      if (input_axis_tvalid[(int'(r_last_grant) + 1 + k) % PORTS])
        w_win = GW'((int'(r_last_grant) + 1 + k) % PORTS);
  end
  always_ff @(posedge clk or posedge async_rst)
    if (async_rst)   r_last_grant <= GW'(PORTS-1);
    else if (w_last) r_last_grant <= r_grant;
`else
  always_comb begin
    w_win = '0;
    for (int k = PORTS-1; k >= 0; k--)
      if (input_axis_tvalid[k]) w_win = GW'(k);
  end
`endif

  always_comb w_state_nxt = (r_state == IDLE) ? (w_any ? BUSY : IDLE) : (w_last ? IDLE : BUSY);

  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) r_state <= IDLE;
    else           r_state <= w_state_nxt;

  always_ff @(posedge clk or posedge async_rst)
    if (async_rst)                      r_grant <= '0;
    else if (r_state == IDLE && w_any)  r_grant <= w_win;

  always_ff @(posedge clk or posedge async_rst)
    if (async_rst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else if (w_accept) begin
      r_tvalid <= 1'b1;
      r_tdata  <= input_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
      r_tlast  <= input_axis_tlast[r_grant];
      r_tuser  <= input_axis_tuser[r_grant];
    end else if (output_axis_tready) begin
      r_tvalid <= 1'b0;
    end
endmodule
